// File: rtl/elevator_ctrl.sv
// Two-floor elevator controller: edge-detects hall/car calls, latches them as requests,
// and sequences the car through idle, travel and door phases with registered outputs.
module elevator_ctrl #(
    parameter int unsigned MOVE_CYCLES = 50_000_000,
    parameter int unsigned DOOR_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       toOne,
    input  logic       toTwo,
    output logic       floor,
    output logic       moving_up,
    output logic       moving_dn,
    output logic       door_open,
    output logic [3:0] req_lamp,
    output logic       busy
);

    localparam int unsigned MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DN,
        DOOR
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_in_d;
    logic [3:0]    r_req;
    logic          r_floor;

    state_t        w_nxt_state;
    logic [CW-1:0] w_nxt_cnt;
    logic          w_nxt_floor;
    logic [3:0]    w_in;
    logic [3:0]    w_rise;
    logic [3:0]    w_here;
    logic [3:0]    w_there;
    logic [3:0]    w_clr;
    logic [3:0]    w_nxt_req;

    // Request bit layout {toTwo, toOne, down, up}: floor 2 owns bits 3/1, floor 1 owns 2/0.
    function automatic logic [3:0] floor_bits(input logic f);
        return f ? 4'b1010 : 4'b0101;
    endfunction

    assign w_in    = {toTwo, toOne, down, up};
    assign w_rise  = w_in & ~r_in_d;
    assign w_here  = floor_bits(r_floor);
    assign w_there = floor_bits(~r_floor);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + CW'(1);
        w_nxt_floor = r_floor;
        w_clr       = '0;
        case (r_state)
            IDLE: begin
                w_nxt_cnt = '0;
                if (|(r_req & w_here)) begin
                    w_nxt_state = DOOR;
                    w_clr       = w_here;
                end else if (|(r_req & w_there)) begin
                    w_nxt_state = r_floor ? MOVE_DN : MOVE_UP;
                end
            end
            MOVE_UP, MOVE_DN: begin
                if (r_cnt == MOVE_LAST) begin
                    w_nxt_state = DOOR;
                    w_nxt_floor = ~r_floor;
                    w_nxt_cnt   = '0;
                    w_clr       = w_there;
                end
            end
            DOOR: begin
                // A fresh call for this floor re-opens the door rather than queueing a trip.
                if (|(r_req & w_here)) begin
                    w_clr     = w_here;
                    w_nxt_cnt = '0;
                end else if (r_cnt == DOOR_LAST) begin
                    w_nxt_state = IDLE;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
        w_nxt_req = (r_req & ~w_clr) | w_rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_in_d    <= '0;
            r_req     <= '0;
            r_floor   <= 1'b0;
            moving_up <= 1'b0;
            moving_dn <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_in_d    <= w_in;
            r_req     <= w_nxt_req;
            r_floor   <= w_nxt_floor;
            moving_up <= (w_nxt_state == MOVE_UP);
            moving_dn <= (w_nxt_state == MOVE_DN);
            door_open <= (w_nxt_state == DOOR);
            busy      <= (w_nxt_state != IDLE);
        end
    end

    assign floor    = r_floor;
    assign req_lamp = r_req;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: a phase/timer reference model predicts every cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_elevator_ctrl;

    localparam int MOVE_T = 8;
    localparam int DOOR_T = 4;

    logic       clk;
    logic       rst;
    logic       up;
    logic       down;
    logic       toOne;
    logic       toTwo;
    logic       floor;
    logic       moving_up;
    logic       moving_dn;
    logic       door_open;
    logic [3:0] req_lamp;
    logic       busy;

    elevator_ctrl #(
        .MOVE_CYCLES(MOVE_T),
        .DOOR_CYCLES(DOOR_T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .toOne    (toOne),
        .toTwo    (toTwo),
        .floor    (floor),
        .moving_up(moving_up),
        .moving_dn(moving_dn),
        .door_open(door_open),
        .req_lamp (req_lamp),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    int c_door  = 0;
    int c_up    = 0;

    logic [8:0] exp_q[$];

    // Reference model: a phase (idle / travelling with direction / door) plus a countdown of
    // cycles left in that phase.
    logic [3:0] m_in_d;
    logic [3:0] m_req;
    logic       m_floor;
    logic       m_door;
    int         m_dir;
    int         m_left;

    function automatic logic [3:0] fbits(input logic f);
        return f ? 4'b1010 : 4'b0101;
    endfunction

    task automatic model_reset();
        m_in_d  = '0;
        m_req   = '0;
        m_floor = 1'b0;
        m_door  = 1'b0;
        m_dir   = 0;
        m_left  = 0;
    endtask

    task automatic model_step(input logic [3:0] in);
        logic [3:0] rise;
        logic [3:0] clr;
        logic [3:0] here;
        rise   = in & ~m_in_d;
        m_in_d = in;
        clr    = '0;
        here   = fbits(m_floor);
        if (m_door) begin
            if ((m_req & here) != 4'b0) begin
                clr    = here;
                m_left = DOOR_T;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) m_door = 1'b0;
            end
        end else if (m_dir != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_floor = ~m_floor;
                m_dir   = 0;
                m_door  = 1'b1;
                m_left  = DOOR_T;
                clr     = fbits(m_floor);
            end
        end else begin
            if ((m_req & here) != 4'b0) begin
                m_door = 1'b1;
                m_left = DOOR_T;
                clr    = here;
            end else if ((m_req & ~here) != 4'b0) begin
                m_dir  = m_floor ? -1 : 1;
                m_left = MOVE_T;
            end
        end
        m_req = (m_req & ~clr) | rise;
    endtask

    function automatic logic [8:0] expv();
        logic mu;
        logic md;
        mu = (m_dir == 1) && !m_door;
        md = (m_dir == -1) && !m_door;
        return {m_floor, mu, md, m_door, m_req, (m_door || m_dir != 0)};
    endfunction

    function automatic logic [8:0] actv();
        return {floor, moving_up, moving_dn, door_open, req_lamp, busy};
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Called at a falling edge: drive inputs, predict the state after the next rising edge.
    task automatic step(input logic [3:0] in);
        c_door += int'(door_open);
        c_up   += int'(moving_up);
        {toTwo, toOne, down, up} = in;
        if (!rst) model_reset();
        else model_step(in);
        exp_q.push_back(expv());
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(4'b0000);
    endtask

    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle", actv(), e);
            end
        end
    end

    initial begin : driver
        logic [3:0] in;
        logic [3:0] prev;
        rst = 1'b0;
        {toTwo, toOne, down, up} = 4'b0000;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", actv(), 9'b0);

        rst = 1'b1;
        idle_steps(50);
        chk("quiet_50", actv(), 9'b0);

        c_door = 0; c_up = 0;
        step(4'b1000);
        idle_steps(19);
        chk_int("toTwo_up_cycles", c_up, 8);
        chk_int("toTwo_door_cycles", c_door, 4);
        chk("toTwo_final", actv(), {1'b1, 8'b0});

        step(4'b0100);
        idle_steps(25);
        c_door = 0; c_up = 0;
        for (int i = 0; i < 30; i++) step(4'b0001);
        idle_steps(10);
        chk_int("up_held_door_cycles", c_door, 4);
        chk_int("up_held_up_cycles", c_up, 0);

        c_door = 0; c_up = 0;
        step(4'b0110);
        idle_steps(25);
        chk_int("both_door_cycles", c_door, 8);
        chk_int("both_up_cycles", c_up, 8);

        c_door = 0;
        step(4'b0010);
        step(4'b0000);
        step(4'b0000);
        step(4'b1000);
        idle_steps(10);
        chk_int("reopen_door_cycles", c_door, 7);

        prev = '0;
        for (int i = 0; i < 1500; i++) begin
            in = '0;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) in[b] = 1'b1;
            if ($urandom_range(0, 3) == 0) in = prev;
            prev = in;
            step(in);
        end
        idle_steps(40);
        if (m_floor) begin
            step(4'b0100);
            idle_steps(30);
        end

        step(4'b1000);
        idle_steps(6);
        chk("pre_reset_move", actv(), expv());
        rst = 1'b0;
        #1;
        chk("async_reset", actv(), 9'b0);
        idle_steps(3);
        rst = 1'b1;
        idle_steps(5);

        @(posedge clk);
        #2;
        chk_int("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
